// File: rtl/vram_access_ctrl.sv
// Front-end sequencer for a single-port synchronous video RAM: post-reset clear,
// then per-cycle arbitration of the RAM port between video fetch and the Z80 bus.
`timescale 1ns/1ps

module vram_access_ctrl #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8,
  parameter int clear_val_g  = 0,
  parameter int starve_max_g = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [addr_width_g-1:0] cpu_addr,
  input  logic [data_width_g-1:0] cpu_din,
  output logic [data_width_g-1:0] cpu_dout,
  output logic                    cpu_ack,
  input  logic                    vid_req,
  input  logic [addr_width_g-1:0] vid_addr,
  output logic [data_width_g-1:0] vid_dout,
  output logic                    vid_valid,
  output logic                    vid_miss,
  output logic                    init_busy,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q
);

  localparam logic [3:0]              STARVE_MAX = 4'(starve_max_g);
  localparam logic [data_width_g-1:0] CLEAR_VAL  = data_width_g'(clear_val_g);
  localparam logic [addr_width_g:0]   CNT_ONE    = {{addr_width_g{1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [addr_width_g:0]   r_clr_cnt;
  logic [addr_width_g:0]   w_clr_cnt_inc;
  logic                    w_clr_done;
  logic [3:0]              r_starve;
  logic                    w_starved;

  logic [addr_width_g-1:0] r_ram_address;
  logic [data_width_g-1:0] r_ram_data;
  logic                    r_ram_wren;
  logic                    r_init_busy;

  logic                    r_vid_s1;
  logic                    r_vid_s2;
  logic                    r_vid_valid;
  logic [data_width_g-1:0] r_vid_dout;
  logic                    r_vid_miss;

  logic                    r_cpu_busy;
  logic                    r_cpu_wr_s1;
  logic                    r_cpu_rd_s1;
  logic                    r_cpu_rd_s2;
  logic                    r_cpu_ack;
  logic [data_width_g-1:0] r_cpu_dout;

  logic                    w_cpu_elig;
  logic                    w_cpu_issue;
  logic                    w_vid_issue;
  logic                    w_vid_refused;
  logic                    w_cpu_lost;

  // The extra counter bit flips exactly when the top address has been issued.
  assign w_clr_cnt_inc = r_clr_cnt + CNT_ONE;
  assign w_clr_done    = w_clr_cnt_inc[addr_width_g];

  assign w_starved  = (r_starve == STARVE_MAX);
  assign w_cpu_elig = cpu_req & ~r_cpu_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cpu_issue   = 1'b0;
    w_vid_issue   = 1'b0;
    w_vid_refused = 1'b0;
    w_cpu_lost    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (w_clr_done) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Video owns the slot unless the CPU has already lost too many in a row.
        w_cpu_issue   = w_cpu_elig & (~vid_req | w_starved);
        w_vid_issue   = vid_req & ~w_cpu_issue;
        w_vid_refused = vid_req & w_cpu_issue;
        w_cpu_lost    = w_cpu_elig & ~w_cpu_issue;
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clr_cnt     <= '0;
      r_starve      <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_init_busy   <= 1'b1;
      r_vid_s1      <= 1'b0;
      r_vid_s2      <= 1'b0;
      r_vid_valid   <= 1'b0;
      r_vid_dout    <= '0;
      r_vid_miss    <= 1'b0;
      r_cpu_busy    <= 1'b0;
      r_cpu_wr_s1   <= 1'b0;
      r_cpu_rd_s1   <= 1'b0;
      r_cpu_rd_s2   <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_cpu_dout    <= '0;
    end else begin
      r_ram_wren  <= 1'b0;
      r_vid_miss  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;

      r_vid_s1    <= w_vid_issue;
      r_vid_s2    <= r_vid_s1;
      r_cpu_wr_s1 <= w_cpu_issue & cpu_wr;
      r_cpu_rd_s1 <= w_cpu_issue & ~cpu_wr;
      r_cpu_rd_s2 <= r_cpu_rd_s1;

      if (r_state == ST_CLEAR) begin
        r_ram_address <= r_clr_cnt[addr_width_g-1:0];
        r_ram_data    <= CLEAR_VAL;
        r_ram_wren    <= 1'b1;
        r_clr_cnt     <= w_clr_cnt_inc;
        r_init_busy   <= 1'b1;
      end else begin
        r_init_busy <= 1'b0;
        r_vid_miss  <= w_vid_refused;
        if (w_cpu_issue) begin
          r_ram_address <= cpu_addr;
          r_ram_wren    <= cpu_wr;
          if (cpu_wr) begin
            r_ram_data <= cpu_din;
          end
          r_cpu_busy <= 1'b1;
          r_starve   <= '0;
        end else if (w_vid_issue) begin
          r_ram_address <= vid_addr;
        end
        if (w_cpu_lost && !w_starved) begin
          r_starve <= r_starve + 4'd1;
        end
      end

      // RAM q is valid for the op issued two edges ago.
      if (r_vid_s2) begin
        r_vid_dout  <= ram_q;
        r_vid_valid <= 1'b1;
      end
      if (r_cpu_wr_s1) begin
        r_cpu_ack  <= 1'b1;
        r_cpu_busy <= 1'b0;
      end
      if (r_cpu_rd_s2) begin
        r_cpu_dout <= ram_q;
        r_cpu_ack  <= 1'b1;
        r_cpu_busy <= 1'b0;
      end
    end
  end

  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
  assign init_busy   = r_init_busy;
  assign vid_dout    = r_vid_dout;
  assign vid_valid   = r_vid_valid;
  assign vid_miss    = r_vid_miss;
  assign cpu_dout    = r_cpu_dout;
  assign cpu_ack     = r_cpu_ack;

endmodule
